rom: RTL and testbench
======================

ROM -- requirements
Module: rom

Interface
REQ-001 Parameter InstMemNum, default 131072, number of 32-bit instruction words stored (>= 1).
REQ-002 Parameter InstAddrWidth, default 32, width of the byte address bus.
REQ-003 Parameter InstDataWidth, default 32, width of one instruction word.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high (RstEnable = 1).
REQ-006 ce  input  1  chip enable, active-high (ChipEnable = 1).
REQ-007 addr  input  InstAddrWidth  byte address of the instruction to fetch.
REQ-008 inst  output  InstDataWidth  registered instruction word.
REQ-009 Storage SHALL be a word array named rom_data, indices 0..InstMemNum-1, each InstDataWidth wide, loadable by hierarchical $readmemh from a bench.

Function
REQ-010 Word index SHALL be addr >> 2; addr[1:0] ignored (no misalignment fault).
REQ-011 Read latency: on a rising edge with rst=0 and ce=1, inst SHALL take rom_data[index]; new value visible after that edge.
REQ-012 Rising edge with rst=0 and ce=0: inst SHALL become 0.
REQ-013 rst has priority over ce: rising edge with rst=1 SHALL set inst to 0 regardless of ce/addr.
REQ-014 inst SHALL be held stable between rising edges; no combinational path from addr/ce to inst.
REQ-015 Storage SHALL be read-only from the port side; no write path exists.
REQ-016 Every rom_data word SHALL be zeroed in an initial block at time 0, so words not covered by a later load read as 0, never X.
REQ-017 Consecutive reads at different addresses on successive edges SHALL each return their own word (one read per cycle, full throughput).
REQ-018 Out-of-range index (index >= InstMemNum): behaviour per REQ-022/REQ-023.

Reset
REQ-019 Reset SHALL clear only the inst register to 0; rom_data contents SHALL survive reset unchanged.
REQ-020 Reset asserted mid-stream SHALL zero inst on the next edge; the first edge after rst deasserts with ce=1 SHALL return the addressed word again.
REQ-021 No asynchronous behaviour; a reset pulse not spanning a rising edge has no effect.

Configuration
REQ-022 Macro ROM_BOUNDS_CHECK_EN defined: an index >= InstMemNum SHALL yield inst = 0 (no wrap, no X).
REQ-023 Macro ROM_BOUNDS_CHECK_EN undefined: index SHALL wrap modulo InstMemNum (low-order bits only when InstMemNum is a power of two; otherwise index % InstMemNum).

Verification
REQ-024 InstMemNum=32, words 0..3 loaded 0x34011100,0x34020020,0x3403ff00,0x3404ffff; ce=1, addr=0,4,8,12 on successive edges -> inst returns those four words, each one edge after addr applied.
REQ-025 Same setup, addr=16..124 step 4 -> inst = 0x00000000 for every unloaded word (no X).
REQ-026 ce=0, addr=4 -> inst = 0 after the edge; ce=1 next edge -> 0x34020020.
REQ-027 Read addr=8 (inst=0x3403ff00), then rst=1 one edge -> inst=0; rst=0, addr=8 -> 0x3403ff00 again (contents intact).
REQ-028 addr=5 -> same word as addr=4 (0x34020020).
REQ-029 addr=128 (index 32, InstMemNum=32): with ROM_BOUNDS_CHECK_EN -> 0; without -> word 0 (0x34011100).

Source files
------------

// File: rtl/rom.sv
// Instruction ROM: byte address in, registered 32-bit word out. Optional ROM_BOUNDS_CHECK_EN zeroes out-of-range reads, otherwise the index wraps.
// Latency: one clk edge from addr/ce to inst; full throughput, one read per cycle.
// Backpressure: none; ce=0 or rst=1 forces inst to zero on the next edge.
module rom #(
    parameter int InstMemNum    = 131072,
    parameter int InstAddrWidth = 32,
    parameter int InstDataWidth = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic [InstAddrWidth-1:0] addr,
    output logic [InstDataWidth-1:0] inst
);

    localparam int IdxW   = (InstMemNum > 1) ? $clog2(InstMemNum) : 1;
    localparam int WideW  = (InstAddrWidth > 32) ? InstAddrWidth : 32;
    localparam bit IsPow2 = ((InstMemNum & (InstMemNum - 1)) == 0);

    logic [InstDataWidth-1:0] rom_data [0:InstMemNum-1];

    initial begin
        for (int i = 0; i < InstMemNum; i++) begin
            rom_data[i] = '0;
        end
    end

    logic [WideW-1:0]         w_idx_wide;
    logic [IdxW-1:0]          w_idx;
    logic                     w_in_range;
    logic [InstDataWidth-1:0] w_rd_word;
    logic                     w_unused;
    logic [InstDataWidth-1:0] r_inst;

    // Word index; the two byte-offset bits are dropped with no alignment check.
    assign w_idx_wide = WideW'(addr) >> 2;
    assign w_in_range = (w_idx_wide < WideW'(InstMemNum));
    assign w_unused   = ^{addr[1:0], w_idx_wide};

    generate
        if (InstMemNum == 1) begin : g_idx_single
            assign w_idx = '0;
        end else if (IsPow2) begin : g_idx_pow2
            assign w_idx = w_idx_wide[IdxW-1:0];
        end else begin : g_idx_mod
            assign w_idx = IdxW'(w_idx_wide % WideW'(InstMemNum));
        end
    endgenerate

`ifdef ROM_BOUNDS_CHECK_EN
    assign w_rd_word = w_in_range ? rom_data[w_idx] : '0;
`else
    assign w_rd_word = rom_data[w_idx];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst <= '0;
        end else if (!ce) begin
            r_inst <= '0;
        end else begin
            r_inst <= w_rd_word;
        end
    end

    assign inst = r_inst;

endmodule

// File: tb/tb_rom.sv
// Directed bench for rom with a 32-word image; out-of-range expectations follow ROM_BOUNDS_CHECK_EN.
module tb_rom;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;

    int n_vec = 0;
    int n_bad = 0;

    rom #(
        .InstMemNum   (32),
        .InstAddrWidth(32),
        .InstDataWidth(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .addr(addr),
        .inst(inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs, let one rising edge pass, return 1ns after it.
    task automatic step(input logic r, input logic c, input logic [31:0] a);
        rst  = r;
        ce   = c;
        addr = a;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] img [0:3];
    logic [31:0] exp_oob0;
    logic [31:0] exp_oob1;

    initial begin
        img[0] = 32'h34011100;
        img[1] = 32'h34020020;
        img[2] = 32'h3403ff00;
        img[3] = 32'h3404ffff;
`ifdef ROM_BOUNDS_CHECK_EN
        exp_oob0 = 32'h0;
        exp_oob1 = 32'h0;
`else
        exp_oob0 = img[0];
        exp_oob1 = img[1];
`endif
        rst  = 1'b1;
        ce   = 1'b0;
        addr = '0;
        #1;
        for (int i = 0; i < 4; i++) dut.rom_data[i] = img[i];

        step(1'b1, 1'b0, 32'h0);
        chk("reset", inst, 32'h0);

        // Successive reads, one word per edge.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'(i * 4));
            chk($sformatf("seq_addr%0d", i * 4), inst, img[i]);
        end

        // Output must not follow addr/ce between edges.
        addr = 32'h0;
        ce   = 1'b0;
        #2;
        chk("hold_between_edges", inst, img[3]);

        for (int a = 16; a <= 124; a += 4) begin
            step(1'b0, 1'b1, 32'(a));
            chk($sformatf("unloaded_addr%0d", a), inst, 32'h0);
        end

        step(1'b0, 1'b1, 32'd12);
        chk("pre_ce_off", inst, img[3]);
        step(1'b0, 1'b0, 32'd4);
        chk("ce_off", inst, 32'h0);
        step(1'b0, 1'b1, 32'd4);
        chk("ce_on", inst, img[1]);

        step(1'b0, 1'b1, 32'd8);
        chk("pre_reset_read", inst, img[2]);
        step(1'b1, 1'b1, 32'd8);
        chk("reset_over_ce", inst, 32'h0);
        step(1'b0, 1'b1, 32'd8);
        chk("post_reset_read", inst, img[2]);

        // Reset pulse between edges must be ignored.
        rst = 1'b1;
        #1;
        chk("no_async_clear", inst, img[2]);
        rst = 1'b0;
        step(1'b0, 1'b1, 32'd12);
        chk("after_short_pulse", inst, img[3]);

        step(1'b0, 1'b1, 32'd5);
        chk("misaligned_5", inst, img[1]);
        step(1'b0, 1'b1, 32'd11);
        chk("misaligned_11", inst, img[2]);
        step(1'b0, 1'b1, 32'd2);
        chk("misaligned_2", inst, img[0]);

        step(1'b0, 1'b1, 32'd128);
        chk("oob_addr128", inst, exp_oob0);
        step(1'b0, 1'b1, 32'd132);
        chk("oob_addr132", inst, exp_oob1);
        step(1'b0, 1'b1, 32'd12);
        chk("in_range_after_oob", inst, img[3]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
